// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage unit: branch resolve, data-memory load/store with stall and timeout
// Drives the MEM/WB registered outputs; holds the pipeline while a bus access is outstanding.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_to_reg_in,
  input  logic        branch_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] branch_target_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        zero_flag_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic        pc_src_out,
  output logic [31:0] branch_target_out,
  output logic        regwrite_out,
  output logic [1:0]  mem_to_reg_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] read_data_out,
  output logic [4:0]  rd_out,
  output logic        bus_error_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        regwrite_q, regwrite_d;
  logic [1:0]  mem_to_reg_q, mem_to_reg_d;
  logic [31:0] alu_result_q, alu_result_d, read_data_q, read_data_d;
  logic [4:0]  rd_q, rd_d;
  logic        access, illegal;

  assign access  = mem_read_in | mem_write_in;
  assign illegal = (mem_read_in & mem_write_in) | (alu_result_in[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    // MEM/WB defaults to a bubble; only IDLE-without-access and DONE forward the instruction
    regwrite_d   = 1'b0;
    mem_to_reg_d = 2'b00;
    alu_result_d = 32'h0;
    read_data_d  = 32'h0;
    rd_d         = 5'h0;
    stall_out    = 1'b0;
    pc_src_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_out = 1'b1;
          rdata_d   = 32'h0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = mem_write_in;
            addr_d  = alu_result_in;
            wdata_d = write_data_in;
            cnt_d   = 8'd0;
            state_d = ACCESS;
          end
        end else begin
          pc_src_out   = branch_in & zero_flag_in;
          regwrite_d   = regwrite_in;
          mem_to_reg_d = mem_to_reg_in;
          alu_result_d = alu_result_in;
          rd_d         = rd_in;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (dmem_ready) begin
          rdata_d = we_q ? 32'h0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        regwrite_d   = regwrite_in & ~err_q;
        mem_to_reg_d = mem_to_reg_in;
        alu_result_d = alu_result_in;
        read_data_d  = rdata_q;
        rd_d         = rd_in;
        err_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      cnt_q        <= 8'd0;
      regwrite_q   <= 1'b0;
      mem_to_reg_q <= 2'b00;
      alu_result_q <= 32'h0;
      read_data_q  <= 32'h0;
      rd_q         <= 5'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      regwrite_q   <= regwrite_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
    end
  end

  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign branch_target_out = branch_target_in;
  assign regwrite_out      = regwrite_q;
  assign mem_to_reg_out    = mem_to_reg_q;
  assign alu_result_out    = alu_result_q;
  assign read_data_out     = read_data_q;
  assign rd_out            = rd_q;
  assign bus_error_out     = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Each task drives one scenario and compares against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_in, mem_read_in, mem_write_in, branch_in, zero_flag_in;
  logic [1:0]  mem_to_reg_in;
  logic [31:0] alu_result_in, branch_target_in, write_data_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_out, pc_src_out, regwrite_out, bus_error_out;
  logic [31:0] branch_target_out, alu_result_out, read_data_out;
  logic [1:0]  mem_to_reg_out;
  logic [4:0]  rd_out;

  int asserts  = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .regwrite_in(regwrite_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in), .alu_result_in(alu_result_in),
    .branch_target_in(branch_target_in), .write_data_in(write_data_in), .rd_in(rd_in),
    .zero_flag_in(zero_flag_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
    .regwrite_out(regwrite_out), .mem_to_reg_out(mem_to_reg_out), .alu_result_out(alu_result_out),
    .read_data_out(read_data_out), .rd_out(rd_out), .bus_error_out(bus_error_out)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    regwrite_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
    branch_in = 0; zero_flag_in = 0; alu_result_in = 0; branch_target_in = 0;
    write_data_in = 0; rd_in = 0; dmem_rdata = 0; dmem_ready = 0;
  endtask

  // Plays the memory side and records what the bus did; returns positioned #1 after the edge into DONE.
  task automatic run_mem(input int wait_n, input bit never_ready, output int cycles, output int req_cycles,
                         output logic [31:0] a0, output logic w0, output logic [31:0] d0, output bit changed);
    cycles = 0; req_cycles = 0; changed = 0; a0 = 0; w0 = 0; d0 = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (stall_out === 1'b0) break;
      cycles++;
      if (dmem_req === 1'b1) begin
        if (req_cycles == 0) begin a0 = dmem_addr; w0 = dmem_we; d0 = dmem_wdata; end
        else if (dmem_addr !== a0 || dmem_we !== w0 || dmem_wdata !== d0) changed = 1;
        req_cycles++;
        dmem_ready = !never_ready && (req_cycles == wait_n + 1);
      end
      @(posedge clk); #1;
      dmem_ready = 0;
    end
  endtask

  task automatic test_reset();
    reset = 0; clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    asserts++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    asserts++; if (regwrite_out !== 1'b0 || rd_out !== 5'd0 || alu_result_out !== 32'h0 || read_data_out !== 32'h0)
      begin failures++; $display("FAIL reset_wb: got rw=%b rd=%0d alu=%h rdata=%h expected all 0", regwrite_out, rd_out, alu_result_out, read_data_out); end
    asserts++; if (bus_error_out !== 1'b0 || stall_out !== 1'b0) begin failures++; $display("FAIL reset_flags: got err=%b stall=%b expected 0/0", bus_error_out, stall_out); end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_add();
    @(negedge clk);
    regwrite_in = 1; rd_in = 5; alu_result_in = 32'h10; mem_to_reg_in = 2'd2;
    #1;
    asserts++; if (stall_out !== 1'b0) begin failures++; $display("FAIL add_stall: got %b expected 0", stall_out); end
    @(posedge clk); #1;
    asserts++; if (regwrite_out !== 1'b1 || rd_out !== 5'd5 || alu_result_out !== 32'h10 || read_data_out !== 32'h0 || mem_to_reg_out !== 2'd2)
      begin failures++; $display("FAIL add_wb: got rw=%b rd=%0d alu=%h rdata=%h m2r=%0d expected 1/5/10/0/2", regwrite_out, rd_out, alu_result_out, read_data_out, mem_to_reg_out); end
    clear_inputs();
  endtask

  task automatic test_load();
    int cyc, reqc; logic [31:0] a0, d0; logic w0; bit chg;
    @(negedge clk);
    regwrite_in = 1; mem_read_in = 1; rd_in = 7; alu_result_in = 32'h100; mem_to_reg_in = 2'd1;
    dmem_rdata = 32'hDEAD_BEEF;
    run_mem(0, 0, cyc, reqc, a0, w0, d0, chg);
    asserts++; if (cyc !== 2) begin failures++; $display("FAIL load_stall_cycles: got %0d expected 2", cyc); end
    asserts++; if (a0 !== 32'h100 || w0 !== 1'b0) begin failures++; $display("FAIL load_bus: got addr=%h we=%b expected 100/0", a0, w0); end
    asserts++; if (dmem_req !== 1'b0 || bus_error_out !== 1'b0) begin failures++; $display("FAIL load_done: got req=%b err=%b expected 0/0", dmem_req, bus_error_out); end
    @(posedge clk); #1;
    asserts++; if (read_data_out !== 32'hDEAD_BEEF || regwrite_out !== 1'b1 || rd_out !== 5'd7 || mem_to_reg_out !== 2'd1)
      begin failures++; $display("FAIL load_wb: got rdata=%h rw=%b rd=%0d m2r=%0d expected deadbeef/1/7/1", read_data_out, regwrite_out, rd_out, mem_to_reg_out); end
    clear_inputs();
  endtask

  task automatic test_store_wait();
    int cyc, reqc; logic [31:0] a0, d0; logic w0; bit chg; bit err_seen;
    @(negedge clk);
    mem_write_in = 1; alu_result_in = 32'h200; write_data_in = 32'h1234_5678; dmem_rdata = 32'hFFFF_0000;
    run_mem(3, 0, cyc, reqc, a0, w0, d0, chg);
    err_seen = bus_error_out;
    asserts++; if (cyc !== 5) begin failures++; $display("FAIL store_stall_cycles: got %0d expected 5", cyc); end
    asserts++; if (a0 !== 32'h200 || w0 !== 1'b1 || d0 !== 32'h1234_5678 || chg !== 1'b0)
      begin failures++; $display("FAIL store_bus: got addr=%h we=%b wdata=%h changed=%b expected 200/1/12345678/0", a0, w0, d0, chg); end
    asserts++; if (reqc !== 4) begin failures++; $display("FAIL store_req_cycles: got %0d expected 4", reqc); end
    @(posedge clk); #1;
    asserts++; if (err_seen !== 1'b0 || read_data_out !== 32'h0) begin failures++; $display("FAIL store_wb: got err=%b rdata=%h expected 0/0", err_seen, read_data_out); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int cyc, reqc; logic [31:0] a0, d0; logic w0; bit chg;
    @(negedge clk);
    regwrite_in = 1; mem_read_in = 1; rd_in = 9; alu_result_in = 32'h300;
    run_mem(0, 1, cyc, reqc, a0, w0, d0, chg);
    asserts++; if (reqc !== 4) begin failures++; $display("FAIL timeout_req_cycles: got %0d expected 4", reqc); end
    asserts++; if (bus_error_out !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL timeout_err: got err=%b req=%b expected 1/0", bus_error_out, dmem_req); end
    @(posedge clk); #1;
    asserts++; if (bus_error_out !== 1'b0 || regwrite_out !== 1'b0) begin failures++; $display("FAIL timeout_wb: got err=%b rw=%b expected 0/0", bus_error_out, regwrite_out); end
    clear_inputs();
  endtask

  task automatic test_illegal();
    int cyc, reqc; logic [31:0] a0, d0; logic w0; bit chg;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      regwrite_in = 1; rd_in = 3;
      if (k == 0) begin mem_read_in = 1; alu_result_in = 32'h103; end
      else begin mem_read_in = 1; mem_write_in = 1; alu_result_in = 32'h100; end
      run_mem(0, 0, cyc, reqc, a0, w0, d0, chg);
      asserts++; if (cyc !== 1 || reqc !== 0) begin failures++; $display("FAIL illegal%0d_stall: got stall=%0d req=%0d expected 1/0", k, cyc, reqc); end
      asserts++; if (bus_error_out !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL illegal%0d_err: got err=%b req=%b expected 1/0", k, bus_error_out, dmem_req); end
      @(posedge clk); #1;
      asserts++; if (regwrite_out !== 1'b0 || bus_error_out !== 1'b0) begin failures++; $display("FAIL illegal%0d_wb: got rw=%b err=%b expected 0/0", k, regwrite_out, bus_error_out); end
      clear_inputs();
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    branch_in = 1; zero_flag_in = 1; branch_target_in = 32'h40;
    #1;
    asserts++; if (pc_src_out !== 1'b1 || branch_target_out !== 32'h40) begin failures++; $display("FAIL branch_taken: got pc_src=%b tgt=%h expected 1/40", pc_src_out, branch_target_out); end
    zero_flag_in = 0;
    #1;
    asserts++; if (pc_src_out !== 1'b0) begin failures++; $display("FAIL branch_not_taken: got %b expected 0", pc_src_out); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    regwrite_in = 1; mem_write_in = 1; alu_result_in = 32'h400; write_data_in = 32'hCAFE_0001;
    @(posedge clk); #1;
    asserts++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL midrst_pre_req: got %b expected 1", dmem_req); end
    reset = 0;
    @(posedge clk); #1;
    clear_inputs();
    reset = 1;
    #1;
    asserts++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0)
      begin failures++; $display("FAIL midrst_bus: got req=%b we=%b addr=%h wdata=%h expected all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    asserts++; if (stall_out !== 1'b0 || regwrite_out !== 1'b0 || alu_result_out !== 32'h0 || bus_error_out !== 1'b0)
      begin failures++; $display("FAIL midrst_out: got stall=%b rw=%b alu=%h err=%b expected all 0", stall_out, regwrite_out, alu_result_out, bus_error_out); end
    dmem_ready = 1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_ready = 0;
    asserts++; if (dmem_req !== 1'b0 || read_data_out !== 32'h0 || stall_out !== 1'b0)
      begin failures++; $display("FAIL late_ready: got req=%b rdata=%h stall=%b expected 0/0/0", dmem_req, read_data_out, stall_out); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store_wait();
    test_timeout();
    test_illegal();
    test_branch();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
